// File: rtl/adc_clip_pkg.sv
// Shared types and helpers for the ADC clip detector: window FSM states and a
// saturating magnitude for sample widths up to 32 bits.
package adc_clip_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } win_state_e;

  function automatic logic [31:0] mag_max(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // The most negative code has no positive counterpart, so it clamps to mag_max.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int unsigned width);
    logic [31:0] lim;
    lim = mag_max(width);
    if (!x[31]) return x;
    if (x == $signed(~lim)) return lim;
    return -x;
  endfunction

endpackage

// File: rtl/adc_clip_detect_if.sv
// Sample stream and statistics handshake between the ADC front end and the
// clip detector; master is the source/host side, slave is the detector.
interface adc_clip_detect_if #(
  parameter int ADC_W = 16,
  parameter int CNT_W = 16
);
  logic signed [ADC_W-1:0] adc_data;
  logic                    adc_ovr;
  logic                    stat_ack;
  logic [CNT_W-1:0]        clip_count;
  logic [ADC_W-2:0]        peak;
  logic                    stat_valid;
  logic                    stat_lost;

  modport master (
    output adc_data, adc_ovr, stat_ack,
    input  clip_count, peak, stat_valid, stat_lost
  );

  modport slave (
    input  adc_data, adc_ovr, stat_ack,
    output clip_count, peak, stat_valid, stat_lost
  );
endinterface

// File: rtl/clip_stretch.sv
// Retriggerable pulse stretcher: each trig holds level high for HOLD clocks,
// counted from the last trig; clear drops everything on the next clock.
module clip_stretch #(
  parameter int HOLD = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic trig,
  output logic level
);
  localparam int CW = $clog2(HOLD + 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          level_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear)
      cnt_next = '0;
    else if (trig)
      cnt_next = CW'(HOLD);
    else if (cnt_reg != '0)
      cnt_next = cnt_reg - CW'(1);
  end

  // level trails the counter by one clock so it is a clean register output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      level_reg <= !clear && (cnt_reg != '0);
    end
  end

  assign level = level_reg;
endmodule

// File: rtl/adc_clip_detect.sv
// ADC clip detector: OVR/threshold clip flag, stretched overrange output and
// per-window clip statistics. Define ADC_CLIP_PEAK_EN to build peak tracking.
module adc_clip_detect
  import adc_clip_pkg::*;
#(
  parameter int ADC_W = 16,
  parameter int CNT_W = 16,
  parameter int HOLD  = 1024,
  parameter int WIN   = 122880
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [ADC_W-2:0] thresh,
  output logic             adc_overrange,
  adc_clip_detect_if.slave bus
);
  localparam int               WCW      = $clog2(WIN);
  localparam logic [WCW-1:0]   WIN_LAST = WCW'(WIN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic signed [ADC_W-1:0] data_reg;
  logic                    ovr_reg, v1_reg, clip_reg;
  logic [ADC_W-2:0]        mag;
  logic                    clip, clear;

  win_state_e       state_reg, state_next;
  logic [WCW-1:0]   wcnt_reg, wcnt_next;
  logic [CNT_W-1:0] cacc_reg, cacc_next, count_reg, count_next, cnt_sum;
  logic             valid_reg, valid_next, lost_reg, lost_next;
  logic             counting, win_end;

  assign clear = !run;

  // v1_reg marks a sample captured while running, so cleared zeros never clip.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_reg <= '0;
      ovr_reg  <= 1'b0;
      v1_reg   <= 1'b0;
      clip_reg <= 1'b0;
    end else if (clear) begin
      data_reg <= '0;
      ovr_reg  <= 1'b0;
      v1_reg   <= 1'b0;
      clip_reg <= 1'b0;
    end else begin
      data_reg <= bus.adc_data;
      ovr_reg  <= bus.adc_ovr;
      v1_reg   <= 1'b1;
      clip_reg <= clip;
    end
  end

  always_comb begin
    mag  = (ADC_W-1)'(sat_abs(32'(data_reg), ADC_W));
    clip = v1_reg && (ovr_reg || (mag >= thresh));
  end

  clip_stretch #(.HOLD(HOLD)) u_stretch (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .trig  (clip),
    .level (adc_overrange)
  );

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    cacc_next  = cacc_reg;
    count_next = count_reg;
    valid_next = valid_reg;
    lost_next  = lost_reg;
    counting   = 1'b0;
    win_end    = 1'b0;
    cnt_sum    = (clip_reg && (cacc_reg != CNT_MAX)) ? cacc_reg + CNT_W'(1) : cacc_reg;
    case (state_reg)
      IDLE:    state_next = MEASURE;
      MEASURE: begin
        counting = 1'b1;
        win_end  = (wcnt_reg == WIN_LAST);
      end
      default: state_next = IDLE;
    endcase
    if (counting) begin
      wcnt_next = win_end ? '0 : wcnt_reg + WCW'(1);
      if (win_end) begin
        // A new result always wins over a same-clock ack; only an unacked overwrite is lost.
        cacc_next  = '0;
        count_next = cnt_sum;
        valid_next = 1'b1;
        if (valid_reg && !bus.stat_ack)
          lost_next = 1'b1;
      end else begin
        cacc_next = cnt_sum;
        if (bus.stat_ack)
          valid_next = 1'b0;
      end
    end
    if (clear) begin
      state_next = IDLE;
      wcnt_next  = '0;
      cacc_next  = '0;
      count_next = '0;
      valid_next = 1'b0;
      lost_next  = 1'b0;
      counting   = 1'b0;
      win_end    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      wcnt_reg  <= '0;
      cacc_reg  <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
      lost_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      cacc_reg  <= cacc_next;
      count_reg <= count_next;
      valid_reg <= valid_next;
      lost_reg  <= lost_next;
    end
  end

`ifdef ADC_CLIP_PEAK_EN
  logic [ADC_W-2:0] mag_reg, pacc_reg, peak_reg, pacc_max;

  assign pacc_max = (mag_reg > pacc_reg) ? mag_reg : pacc_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mag_reg  <= '0;
      pacc_reg <= '0;
      peak_reg <= '0;
    end else if (clear) begin
      mag_reg  <= '0;
      pacc_reg <= '0;
      peak_reg <= '0;
    end else begin
      mag_reg <= mag;
      if (win_end) begin
        pacc_reg <= '0;
        peak_reg <= pacc_max;
      end else if (counting) begin
        pacc_reg <= pacc_max;
      end
    end
  end

  assign bus.peak = peak_reg;
`else
  assign bus.peak = '0;
`endif

  assign bus.clip_count = count_reg;
  assign bus.stat_valid = valid_reg;
  assign bus.stat_lost  = lost_reg;
endmodule
